// File: rtl/calc_disp_pkg.sv
// ============================================================================
//  Module   : calc_disp_pkg
//  Brief    : Shared glyph constants, converter state encoding and glyph ROM
//             for the calculator result display.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package calc_disp_pkg;

    localparam int DIGITS = 8;

    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_A     = 8'h88;
    localparam logic [7:0] SEG_B     = 8'h83;
    localparam logic [7:0] SEG_C     = 8'hC6;
    localparam logic [7:0] SEG_D     = 8'hA1;
    localparam logic [7:0] SEG_E     = 8'h86;
    localparam logic [7:0] SEG_F     = 8'h8E;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } conv_state_t;

    // Active-low segments, dp bit left unlit.
    function automatic logic [7:0] seg_glyph(input logic [3:0] nib);
        logic [7:0] g;
        case (nib)
            4'h0:    g = SEG_0;
            4'h1:    g = SEG_1;
            4'h2:    g = SEG_2;
            4'h3:    g = SEG_3;
            4'h4:    g = SEG_4;
            4'h5:    g = SEG_5;
            4'h6:    g = SEG_6;
            4'h7:    g = SEG_7;
            4'h8:    g = SEG_8;
            4'h9:    g = SEG_9;
            4'hA:    g = SEG_A;
            4'hB:    g = SEG_B;
            4'hC:    g = SEG_C;
            4'hD:    g = SEG_D;
            4'hE:    g = SEG_E;
            default: g = SEG_F;
        endcase
        return g;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bin2bcd_seq.sv
// ============================================================================
//  Module   : bin2bcd_seq
//  Brief    : Sequential double-dabble, 16-bit binary to 5 BCD digits,
//             one shift per cycle with start/busy/done handshake.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bin2bcd_seq
    import calc_disp_pkg::*;
#(
    parameter int BCD_DIGITS = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [15:0]               bin,
    output logic                      busy,
    output logic                      done,
    output logic [4*BCD_DIGITS-1:0]   bcd,
    output logic [15:0]               latched
);

    localparam int c_bin_w = 16;
    localparam int c_bcd_w = 4 * BCD_DIGITS;

    conv_state_t        r_state;
    conv_state_t        w_next;
    logic [c_bin_w-1:0] r_bin;
    logic [c_bin_w-1:0] r_latched;
    logic [c_bcd_w-1:0] r_bcd;
    logic [c_bcd_w-1:0] w_adj;
    logic [3:0]         r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_next = ST_SHIFT;
            ST_SHIFT: if (r_cnt == 4'(c_bin_w - 1)) w_next = ST_DONE;
            ST_DONE:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state == ST_SHIFT) || (r_state == ST_DONE);
        done = (r_state == ST_DONE);
    end

    // Add-3 correction applied to every digit before the shift.
    for (genvar k = 0; k < BCD_DIGITS; k++) begin : g_adj
        assign w_adj[4*k +: 4] = (r_bcd[4*k +: 4] >= 4'd5) ? r_bcd[4*k +: 4] + 4'd3
                                                            : r_bcd[4*k +: 4];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bin     <= '0;
            r_latched <= '0;
            r_bcd     <= '0;
            r_cnt     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_bin     <= bin;
                        r_latched <= bin;
                        r_bcd     <= '0;
                        r_cnt     <= '0;
                    end
                end
                ST_SHIFT: begin
                    r_bcd <= {w_adj[c_bcd_w-2:0], r_bin[c_bin_w-1]};
                    r_bin <= {r_bin[c_bin_w-2:0], 1'b0};
                    r_cnt <= r_cnt + 4'd1;
                end
                default: ;
            endcase
        end
    end

    assign bcd     = r_bcd;
    assign latched = r_latched;

endmodule

`default_nettype wire

// File: rtl/calc_result_display.sv
// ============================================================================
//  Module   : calc_result_display
//  Brief    : 8-digit multiplexed 7-segment driver for the calculator,
//             hex view of {X,Y,ans} or blanked decimal view of ans.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module calc_result_display
    import calc_disp_pkg::*;
#(
    parameter int SCAN_DIV   = 50000,
    parameter int BCD_DIGITS = 5
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] N,
    input  logic        exceed,
    input  logic        dec_mode,
    output logic [7:0]  codeout,
    output logic [2:0]  sel,
    output logic        busy
);

    localparam int c_presc_w = $clog2(SCAN_DIV);
    localparam int c_bcd_w   = 4 * BCD_DIGITS;
    localparam logic [c_presc_w-1:0] c_presc_term = c_presc_w'(SCAN_DIV - 1);

    logic [c_presc_w-1:0] r_presc;
    logic [2:0]           r_sel;
    logic [7:0]           r_codeout;
    logic [7:0]           w_seg;
    logic [c_bcd_w-1:0]   r_disp_bcd;
    logic [15:0]          r_last;
    logic                 r_valid;
    logic                 w_start;
    logic                 w_done;
    logic [c_bcd_w-1:0]   w_bcd;
    logic [15:0]          w_latched;
    logic [4*DIGITS-1:0]  w_bcd_pad;
    logic [DIGITS-1:0]    w_lz;
    logic [3:0]           w_nib;

    always_ff @(posedge clk) begin
        if (clr) begin
            r_presc <= '0;
            r_sel   <= '0;
        end else if (r_presc == c_presc_term) begin
            r_presc <= '0;
            r_sel   <= r_sel + 3'd1;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    assign w_start = (N[15:0] != r_last) || !r_valid;

    bin2bcd_seq #(
        .BCD_DIGITS (BCD_DIGITS)
    ) u_bcd (
        .clk     (clk),
        .rst     (clr),
        .start   (w_start),
        .bin     (N[15:0]),
        .busy    (busy),
        .done    (w_done),
        .bcd     (w_bcd),
        .latched (w_latched)
    );

    // Display copy only moves on completion, so partial results never show.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_disp_bcd <= '0;
            r_last     <= '0;
            r_valid    <= 1'b0;
        end else if (w_done) begin
            r_disp_bcd <= w_bcd;
            r_last     <= w_latched;
            r_valid    <= 1'b1;
        end
    end

    assign w_bcd_pad = {{(4*DIGITS-c_bcd_w){1'b0}}, r_disp_bcd};

    // w_lz[k]: digit k and everything above it are zero.
    for (genvar k = 0; k < DIGITS; k++) begin : g_lz
        assign w_lz[k] = ~|w_bcd_pad[4*DIGITS-1:4*k];
    end

    always_comb begin
        w_seg = SEG_BLANK;
        w_nib = 4'h0;
        if (!dec_mode) begin
            w_nib = N[{r_sel, 2'b00} +: 4];
            w_seg = seg_glyph(w_nib);
            if (r_sel == 3'd0 && exceed) begin
                w_seg[7] = 1'b0;
            end
        end else if (r_sel < 3'(BCD_DIGITS)) begin
            w_nib = w_bcd_pad[{r_sel, 2'b00} +: 4];
            if (r_sel == 3'd0 || !w_lz[r_sel]) begin
                w_seg = seg_glyph(w_nib);
            end
        end else if (r_sel == 3'(DIGITS - 1) && exceed) begin
            w_seg = SEG_E;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            r_codeout <= SEG_BLANK;
        end else begin
            r_codeout <= w_seg;
        end
    end

    assign codeout = r_codeout;
    assign sel     = r_sel;

endmodule

`default_nettype wire

// File: tb/tb_calc_result_display.sv
// ============================================================================
//  Module   : tb_calc_result_display
//  Brief    : Directed self-checking bench for calc_result_display.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_calc_result_display;

    logic        clk = 1'b0;
    logic        clr;
    logic [31:0] N;
    logic        exceed;
    logic        dec_mode;
    logic [7:0]  codeout;
    logic [2:0]  sel;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    calc_result_display #(
        .SCAN_DIV   (4),
        .BCD_DIGITS (5)
    ) dut (
        .clk      (clk),
        .clr      (clr),
        .N        (N),
        .exceed   (exceed),
        .dec_mode (dec_mode),
        .codeout  (codeout),
        .sel      (sel),
        .busy     (busy)
    );

    // codeout seen at a falling edge belongs to the sel seen one falling edge earlier.
    task automatic read_digit(input int k, output logic [7:0] v);
        logic [2:0] s;
        bit         got;
        got = 1'b0;
        v   = 8'h00;
        @(negedge clk);
        s = sel;
        for (int i = 0; i < 48 && !got; i++) begin
            @(negedge clk);
            if (s == 3'(k)) begin
                v   = codeout;
                got = 1'b1;
            end
            s = sel;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL read_digit_timeout digit=%0d", k);
        end
    endtask

    task automatic count_high(output int n);
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic count_low(output int n);
        n = 0;
        while (!busy && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        clr = 1'b1; N = 32'h0; exceed = 1'b0; dec_mode = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (codeout !== 8'hFF) begin errors++; $display("FAIL reset_codeout got=%h exp=ff", codeout); end
        checks++; if (sel !== 3'd0) begin errors++; $display("FAIL reset_sel got=%0d exp=0", sel); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        clr = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (sel !== 3'd0) begin errors++; $display("FAIL scan_hold got=%0d exp=0", sel); end
        @(negedge clk);
        checks++; if (sel !== 3'd1) begin errors++; $display("FAIL scan_step got=%0d exp=1", sel); end
        repeat (24) @(negedge clk);
        checks++; if (sel !== 3'd7) begin errors++; $display("FAIL scan_seven got=%0d exp=7", sel); end
        repeat (4) @(negedge clk);
        checks++; if (sel !== 3'd0) begin errors++; $display("FAIL scan_wrap got=%0d exp=0", sel); end
    endtask

    task automatic test_hex();
        logic [7:0] exp_tab [8];
        logic [7:0] v;
        exp_tab = '{8'hB0, 8'h8E, 8'hC0, 8'hC0, 8'h83, 8'h88, 8'hA4, 8'hF9};
        dec_mode = 1'b0; exceed = 1'b0; N = 32'h12AB_00F3;
        for (int k = 0; k < 8; k++) begin
            read_digit(k, v);
            checks++;
            if (v !== exp_tab[k]) begin errors++; $display("FAIL hex_digit%0d got=%h exp=%h", k, v, exp_tab[k]); end
        end
        exceed = 1'b1;
        read_digit(0, v);
        checks++; if (v !== 8'h30) begin errors++; $display("FAIL hex_dp got=%h exp=30", v); end
        read_digit(7, v);
        checks++; if (v !== 8'hF9) begin errors++; $display("FAIL hex_dp_other got=%h exp=f9", v); end
        exceed = 1'b0;
    endtask

    task automatic test_dec_max();
        logic [7:0] exp_tab [8];
        logic [7:0] v;
        int n;
        exp_tab = '{8'h92, 8'hB0, 8'h92, 8'h92, 8'h82, 8'hFF, 8'hFF, 8'hFF};
        dec_mode = 1'b1;
        N = 32'h12AB_FFFF;
        @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL dec_busy_start got=%b exp=1", busy); end
        count_high(n);
        checks++; if (n != 17) begin errors++; $display("FAIL dec_busy_len got=%0d exp=17", n); end
        for (int k = 0; k < 8; k++) begin
            read_digit(k, v);
            checks++;
            if (v !== exp_tab[k]) begin errors++; $display("FAIL dec65535_digit%0d got=%h exp=%h", k, v, exp_tab[k]); end
        end
    endtask

    task automatic test_blanking();
        logic [7:0] v;
        int n;
        N = 32'h0000_0007;
        @(negedge clk);
        count_high(n);
        checks++; if (n != 17) begin errors++; $display("FAIL dec7_busy_len got=%0d exp=17", n); end
        read_digit(0, v);
        checks++; if (v !== 8'hF8) begin errors++; $display("FAIL dec7_digit0 got=%h exp=f8", v); end
        for (int k = 1; k < 5; k++) begin
            read_digit(k, v);
            checks++;
            if (v !== 8'hFF) begin errors++; $display("FAIL dec7_digit%0d got=%h exp=ff", k, v); end
        end
        N = 32'h0000_0000;
        @(negedge clk);
        count_high(n);
        read_digit(0, v);
        checks++; if (v !== 8'hC0) begin errors++; $display("FAIL dec0_digit0 got=%h exp=c0", v); end
        read_digit(1, v);
        checks++; if (v !== 8'hFF) begin errors++; $display("FAIL dec0_digit1 got=%h exp=ff", v); end
        read_digit(4, v);
        checks++; if (v !== 8'hFF) begin errors++; $display("FAIL dec0_digit4 got=%h exp=ff", v); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] v;
        int n;
        exceed = 1'b1;
        N = 32'd100;
        @(negedge clk);
        repeat (5) @(negedge clk);
        N = 32'd200;
        @(negedge clk);
        count_high(n);
        checks++; if (n != 11) begin errors++; $display("FAIL b2b_first_rest got=%0d exp=11", n); end
        count_low(n);
        checks++; if (n != 1) begin errors++; $display("FAIL b2b_idle_gap got=%0d exp=1", n); end
        count_high(n);
        checks++; if (n != 17) begin errors++; $display("FAIL b2b_second_len got=%0d exp=17", n); end
        read_digit(0, v);
        checks++; if (v !== 8'hC0) begin errors++; $display("FAIL b2b_digit0 got=%h exp=c0", v); end
        read_digit(2, v);
        checks++; if (v !== 8'hA4) begin errors++; $display("FAIL b2b_digit2 got=%h exp=a4", v); end
        read_digit(3, v);
        checks++; if (v !== 8'hFF) begin errors++; $display("FAIL b2b_digit3 got=%h exp=ff", v); end
        read_digit(7, v);
        checks++; if (v !== 8'h86) begin errors++; $display("FAIL dec_exceed_digit7 got=%h exp=86", v); end
        exceed = 1'b0;
        read_digit(7, v);
        checks++; if (v !== 8'hFF) begin errors++; $display("FAIL dec_noexceed_digit7 got=%h exp=ff", v); end
    endtask

    task automatic test_clr_mid_shift();
        logic [7:0] v;
        int n;
        N = 32'd9999;
        @(negedge clk);
        repeat (4) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL clr_busy got=%b exp=0", busy); end
        checks++; if (codeout !== 8'hFF) begin errors++; $display("FAIL clr_codeout got=%h exp=ff", codeout); end
        checks++; if (sel !== 3'd0) begin errors++; $display("FAIL clr_sel got=%0d exp=0", sel); end
        clr = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL clr_restart got=%b exp=1", busy); end
        count_high(n);
        checks++; if (n != 17) begin errors++; $display("FAIL clr_reconv_len got=%0d exp=17", n); end
        for (int k = 0; k < 4; k++) begin
            read_digit(k, v);
            checks++;
            if (v !== 8'h90) begin errors++; $display("FAIL dec9999_digit%0d got=%h exp=90", k, v); end
        end
        read_digit(4, v);
        checks++; if (v !== 8'hFF) begin errors++; $display("FAIL dec9999_digit4 got=%h exp=ff", v); end
    endtask

    initial begin
        test_reset();
        test_hex();
        test_dec_max();
        test_blanking();
        test_back_to_back();
        test_clr_mid_shift();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
